// File: rtl/instr_encoder.sv
// instr_encoder: packs symbolic MIPS instructions into 32-bit words and streams them to IM.
// ENC_BRANCH_REL_EN: beq takes an absolute word target and encodes the PC-relative offset.
`timescale 1ns/1ps
module instr_encoder #(
    parameter int AW    = 10,
    parameter int DEPTH = 1024
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start,
    input  logic          stop,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    mnem,
    input  logic [4:0]    rs,
    input  logic [4:0]    rt,
    input  logic [4:0]    rd,
    input  logic [4:0]    shamt,
    input  logic [15:0]   imm,
    input  logic [25:0]   target,
    output logic          im_we,
    input  logic          im_ready,
    output logic [AW-1:0] im_addr,
    output logic [31:0]   im_wdata,
    output logic          busy,
    output logic          full,
    output logic          done,
    output logic          err
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FULL, S_DRAIN} state_t;
    // one extra bit so idx can reach DEPTH even when DEPTH == 2^AW
    localparam logic [AW:0] LAST = (AW+1)'(DEPTH - 1);
    state_t st, nxt;
    logic [AW:0] idx;
    logic accept, legal;
    logic [5:0] funct, op;
    logic [15:0] imm_e;
    logic [31:0] word;
    assign accept = in_valid & in_ready;
    assign legal  = mnem != 4'd15;
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) st <= S_IDLE;
        else st <= nxt;
    always_comb begin
        nxt = st;
        case (st)
            S_IDLE:  nxt = start ? S_LOAD : S_IDLE;
            S_LOAD:  nxt = stop ? S_DRAIN : (accept & legal & idx == LAST) ? S_FULL : S_LOAD;
            S_FULL:  nxt = stop ? S_DRAIN : S_FULL;
            default: nxt = im_we ? S_DRAIN : S_IDLE;
        endcase
    end
    always_comb begin
        in_ready = (st == S_LOAD) & (~im_we | im_ready);
        busy     = st != S_IDLE;
        done     = (st == S_DRAIN) & ~im_we;
    end
    always_comb begin
        funct = 6'h00;
        op    = 6'h00;
        case (mnem)
            4'd0:    funct = 6'h20;
            4'd1:    funct = 6'h22;
            4'd2:    funct = 6'h24;
            4'd3:    funct = 6'h25;
            4'd4:    funct = 6'h2A;
            4'd5:    funct = 6'h2B;
            4'd6:    funct = 6'h21;
            4'd7:    funct = 6'h23;
            4'd9:    op = 6'h08;
            4'd10:   op = 6'h0D;
            4'd11:   op = 6'h23;
            4'd12:   op = 6'h2B;
            4'd13:   op = 6'h04;
            4'd14:   op = 6'h02;
            default: funct = 6'h00;
        endcase
    end
`ifdef ENC_BRANCH_REL_EN
    assign imm_e = (mnem == 4'd13) ? 16'(target[AW-1:0]) - 16'(idx + 1'b1) : imm;
`else
    assign imm_e = imm;
`endif
    assign word = (mnem <= 4'd8) ? {6'd0, (mnem == 4'd8) ? 5'd0 : rs, rt, rd, shamt, funct} :
                  (mnem == 4'd14) ? {op, target} : {op, rs, rt, imm_e};
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            idx      <= '0;
            full     <= 1'b0;
            err      <= 1'b0;
            im_we    <= 1'b0;
            im_addr  <= '0;
            im_wdata <= '0;
        end else begin
            if (st == S_IDLE && start) begin
                idx  <= '0;
                full <= 1'b0;
                err  <= 1'b0;
            end
            if (accept & ~legal) err <= 1'b1;
            if (accept & legal) begin
                idx      <= idx + 1'b1;
                full     <= idx == LAST;
                im_we    <= 1'b1;
                im_addr  <= idx[AW-1:0];
                im_wdata <= word;
            end else if (im_ready) im_we <= 1'b0;
        end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: randomized and directed checks of instr_encoder against a table-driven encoding model.
`timescale 1ns/1ps
module tb_instr_encoder;
    localparam int AW = 3;
    localparam int DEPTH = 8;
    localparam logic [5:0] FUNCT [0:8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h2B, 6'h21, 6'h23, 6'h00};
    localparam logic [5:0] OPC [0:4] = '{6'h08, 6'h0D, 6'h23, 6'h2B, 6'h04};
    logic clk = 0, rstn = 0, start = 0, stop = 0, in_valid = 0, im_ready = 0;
    logic in_ready, im_we, busy, full, done, err;
    logic [3:0] mnem = 0;
    logic [4:0] rs = 0, rt = 0, rd = 0, shamt = 0;
    logic [15:0] imm = 0;
    logic [25:0] target = 0;
    logic [AW-1:0] im_addr;
    logic [31:0] im_wdata;
    logic rand_rdy = 0, rdy_force = 1;
    int checks = 0, errors = 0, midx = 0;
    logic err_exp = 0;
    logic [AW+31:0] exp_q[$], got_q[$];

    instr_encoder #(.AW(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rstn(rstn), .start(start), .stop(stop), .in_valid(in_valid), .in_ready(in_ready),
        .mnem(mnem), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .imm(imm), .target(target),
        .im_we(im_we), .im_ready(im_ready), .im_addr(im_addr), .im_wdata(im_wdata),
        .busy(busy), .full(full), .done(done), .err(err)
    );

    always #5 clk = ~clk;
    always @(negedge clk) im_ready <= rand_rdy ? 1'($urandom_range(0, 1)) : rdy_force;
    always @(posedge clk) if (rstn && im_we && im_ready) got_q.push_back({im_addr, im_wdata});

    function automatic logic [31:0] ref_enc(input logic [3:0] m, input logic [4:0] a, b, c, d,
                                            input logic [15:0] i, input logic [25:0] t, input int k);
        logic [15:0] iv;
`ifdef ENC_BRANCH_REL_EN
        int off;
        off = int'(t % (1 << AW)) - (k + 1);
        iv = (m == 4'd13) ? off[15:0] : i;
`else
        iv = i;
`endif
        if (m <= 4'd8) return {6'd0, (m == 4'd8) ? 5'd0 : a, b, c, d, FUNCT[m]};
        if (m == 4'd14) return {6'h02, t};
        return {OPC[m - 4'd9], a, b, iv};
    endfunction

    task automatic send(input logic [3:0] m, input logic [4:0] a, b, c, d, input logic [15:0] i, input logic [25:0] t);
        logic acc = 0;
        mnem = m; rs = a; rt = b; rd = c; shamt = d; imm = i; target = t; in_valid = 1;
        for (int n = 0; n < 50 && !acc; n++) begin
            @(negedge clk); #1;
            acc = in_ready;
            @(posedge clk); #1;
        end
        in_valid = 0;
        if (!acc) begin
            checks++; errors++;
            $display("FAIL send_timeout: in_ready never 1 for mnem=%0d, required an accept", m);
        end else if (m != 4'd15) begin
            exp_q.push_back({AW'(midx), ref_enc(m, a, b, c, d, i, t, midx)});
            midx++;
        end else err_exp = 1;
    endtask

    task automatic do_start;
        midx = 0; err_exp = 0; exp_q.delete(); got_q.delete();
        start = 1;
        @(posedge clk); #1;
        start = 0;
    endtask

    task automatic finish_load;
        logic seen = 0;
        stop = 1;
        @(posedge clk); #1;
        stop = 0;
        for (int n = 0; n < 100 && !seen; n++) begin
            @(negedge clk);
            seen = done;
        end
        @(posedge clk); #1;
        checks++;
        if (!seen) begin errors++; $display("FAIL done_pulse: done never seen, required a pulse"); end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL idle_after_done: busy=%b done=%b, required 0 0", busy, done);
        end
        checks++;
        if (err !== err_exp) begin errors++; $display("FAIL err_flag: got %b, required %b", err, err_exp); end
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL word_count: got %0d, required %0d", got_q.size(), exp_q.size());
        end else
            for (int k = 0; k < exp_q.size(); k++) begin
                checks++;
                if (got_q[k] !== exp_q[k]) begin
                    errors++;
                    $display("FAIL write_%0d: got addr=%0d data=%h, required addr=%0d data=%h",
                             k, got_q[k][AW+31:32], got_q[k][31:0], exp_q[k][AW+31:32], exp_q[k][31:0]);
                end
            end
    endtask

    task automatic test_reset;
        checks++;
        if ({in_ready, im_we, im_addr, im_wdata, busy, full, done, err} !== '0) begin
            errors++;
            $display("FAIL reset_values: in_ready=%b im_we=%b addr=%0d data=%h busy=%b full=%b done=%b err=%b, required all 0",
                     in_ready, im_we, im_addr, im_wdata, busy, full, done, err);
        end
    endtask

    task automatic test_directed;
        logic [3:0] tm [0:4] = '{4'd0, 4'd9, 4'd13, 4'd8, 4'd14};
        logic [4:0] trs [0:4] = '{5'd1, 5'd0, 5'd1, 5'd7, 5'd0};
        logic [4:0] trt [0:4] = '{5'd2, 5'd1, 5'd2, 5'd1, 5'd0};
        logic [4:0] trd [0:4] = '{5'd3, 5'd0, 5'd0, 5'd2, 5'd0};
        logic [4:0] tsh [0:4] = '{5'd0, 5'd0, 5'd0, 5'd4, 5'd0};
        logic [15:0] tim [0:4] = '{16'd0, 16'd5, 16'd3, 16'd0, 16'd0};
        logic [25:0] ttg [0:4] = '{26'd0, 26'd0, 26'd0, 26'd0, 26'h10};
`ifdef ENC_BRANCH_REL_EN
        logic [31:0] tw [0:4] = '{32'h00221820, 32'h20010005, 32'h1022FFFD, 32'h00011100, 32'h08000010};
`else
        logic [31:0] tw [0:4] = '{32'h00221820, 32'h20010005, 32'h10220003, 32'h00011100, 32'h08000010};
`endif
        rand_rdy = 0; rdy_force = 1;
        do_start;
        for (int k = 0; k < 5; k++) begin
            stop = (k == 4);
            send(tm[k], trs[k], trt[k], trd[k], tsh[k], tim[k], ttg[k]);
            stop = 0;
            checks++;
            if (im_we !== 1'b1 || im_addr !== AW'(k) || im_wdata !== tw[k]) begin
                errors++;
                $display("FAIL directed_%0d: im_we=%b addr=%0d data=%h, required 1 %0d %h", k, im_we, im_addr, im_wdata, k, tw[k]);
            end
        end
        finish_load;
    endtask

    task automatic test_stall;
        longint t0;
        rand_rdy = 0; rdy_force = 0;
        do_start;
        send(4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (im_we !== 1'b1 || im_addr !== AW'(0) || im_wdata !== 32'h00221820 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold_%0d: im_we=%b addr=%0d data=%h in_ready=%b, required 1 0 00221820 0",
                         k, im_we, im_addr, im_wdata, in_ready);
            end
        end
        @(posedge clk); #1;
        rdy_force = 1;
        t0 = $time;
        for (int k = 0; k < 4; k++)
            send(4'($urandom_range(0, 14)), 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom), 26'($urandom));
        checks++;
        if ($time - t0 != 40) begin
            errors++; $display("FAIL back_to_back: 4 accepts took %0d ns, required 40", $time - t0);
        end
        finish_load;
    endtask

    task automatic test_illegal;
        rand_rdy = 0; rdy_force = 1;
        do_start;
        send(4'd3, 5'd4, 5'd5, 5'd6, 5'd0, 16'd0, 26'd0);
        send(4'd15, 5'd1, 5'd1, 5'd1, 5'd1, 16'd1, 26'd1);
        checks++;
        if (im_we !== 1'b0 || err !== 1'b1) begin
            errors++; $display("FAIL illegal_nowrite: im_we=%b err=%b, required 0 1", im_we, err);
        end
        send(4'd10, 5'd2, 5'd3, 5'd0, 5'd0, 16'hBEEF, 26'd0);
        checks++;
        if (im_we !== 1'b1 || im_addr !== AW'(1)) begin
            errors++; $display("FAIL illegal_nogap: im_we=%b addr=%0d, required 1 1", im_we, im_addr);
        end
        finish_load;
    endtask

    task automatic test_full;
        rand_rdy = 1;
        do_start;
        for (int k = 0; k < DEPTH; k++) begin
            send(4'($urandom_range(0, 14)), 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom), 26'($urandom));
            checks++;
            if (full !== (k == DEPTH - 1)) begin
                errors++; $display("FAIL full_after_%0d: full=%b, required %b", k + 1, full, k == DEPTH - 1);
            end
        end
        mnem = 4'd0; in_valid = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0) begin errors++; $display("FAIL full_blocks_%0d: in_ready=%b, required 0", k, in_ready); end
        end
        @(posedge clk); #1;
        in_valid = 0;
        finish_load;
        rand_rdy = 0;
    endtask

    task automatic test_random;
        for (int r = 0; r < 4; r++) begin
            rand_rdy = 1;
            do_start;
            for (int k = $urandom_range(1, DEPTH); k > 0; k--)
                send(4'($urandom_range(0, 15)), 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom), 26'($urandom));
            finish_load;
        end
        rand_rdy = 0;
    endtask

    task automatic test_reset_mid;
        rand_rdy = 0; rdy_force = 0;
        do_start;
        send(4'd15, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
        send(4'd1, 5'd9, 5'd8, 5'd7, 5'd0, 16'd0, 26'd0);
        #3 rstn = 0;
        #1;
        checks++;
        if ({in_ready, im_we, im_addr, im_wdata, busy, full, done, err} !== '0) begin
            errors++;
            $display("FAIL reset_mid: in_ready=%b im_we=%b addr=%0d data=%h busy=%b full=%b done=%b err=%b, required all 0",
                     in_ready, im_we, im_addr, im_wdata, busy, full, done, err);
        end
        @(posedge clk); #1;
        rstn = 1; rdy_force = 1;
        exp_q.delete(); got_q.delete(); midx = 0;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || im_we !== 1'b0) begin
            errors++; $display("FAIL reset_mid_idle: busy=%b im_we=%b, required 0 0", busy, im_we);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 test_reset;
        rstn = 1;
        @(posedge clk); #1;
        test_reset;
        test_directed;
        test_stall;
        test_illegal;
        test_full;
        test_random;
        test_reset_mid;
        test_directed;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/instr_encoder.md
# instr_encoder

Streaming MIPS instruction encoder for the single-cycle CPU test infrastructure. It accepts one symbolic instruction per handshake (mnemonic code plus operand fields) and packs it into the 32-bit machine word the CPU control decoder expects. It writes encoded words sequentially into instruction memory through a one-entry output register with backpressure. It sits between the bench/boot sequencer and the IM write port, so programs can be loaded without precompiled hex files.

## Interface
- `AW`, default 10: IM word-address width.
- `DEPTH`, default 1024: maximum words per load; must be ≤ 2^AW.
- `clk` input, 1: clock, rising edge.
- `rstn` input, 1: asynchronous reset, active-low.
- `start` input, 1: begin a program load; honoured only in IDLE.
- `stop` input, 1: end the load after the output drains.
- `in_valid` input, 1: instruction fields valid.
- `in_ready` output, 1: encoder can accept this cycle.
- `mnem` input, 4: mnemonic code (see Operation).
- `rs`, `rt`, `rd`, `shamt` input, 5 each: register and shift fields.
- `imm` input, 16: immediate value.
- `target` input, 26: jump target, or beq absolute word target.
- `im_we` output, 1: output word valid (IM write request).
- `im_ready` input, 1: IM accepts the write this cycle.
- `im_addr` output, AW: word address of `im_wdata`.
- `im_wdata` output, 32: encoded instruction.
- `busy` output, 1: state is not IDLE.
- `full` output, 1: DEPTH words accepted.
- `done` output, 1: one-cycle pulse on return to IDLE.
- `err` output, 1: sticky; illegal mnemonic seen since `start`.

## Operation
- Mnemonic codes and encodings. R-type uses op 0 with fields rs|rt|rd|shamt|funct:
  - 0 add (funct 0x20), 1 sub (0x22), 2 and (0x24), 3 or (0x25), 4 slt (0x2A), 5 sltu (0x2B), 6 addu (0x21), 7 subu (0x23).
  - 8 sll (0x00): rs field forced to 0.
  - I-type, op|rs|rt|imm: 9 addi (op 0x08), 10 ori (0x0D), 11 lw (0x23), 12 sw (0x2B), 13 beq (0x04).
  - 14 j: op 0x02 | target[25:0].
  - 15 illegal.
- R-type ignores `imm` and `target`; I-type ignores `rd`, `shamt`, `target` (except beq with the macro enabled).
- States:
  - IDLE → LOAD on `start`. Clears `idx`, `err`, `full`.
  - LOAD → FULL when `idx` reaches DEPTH on an accept.
  - LOAD or FULL → DRAIN on `stop`.
  - DRAIN → IDLE when the output register is empty; `done` pulses that cycle.
- `in_ready` = (state == LOAD) & (~im_we | im_ready).
- An accept is `in_valid & in_ready`:
  - Legal mnemonic: the word is loaded into the output register with `im_addr` = `idx`, and `idx` increments.
  - Illegal mnemonic: `err` is set, no word is emitted, and `idx` is unchanged.
- `im_we` holds with stable `im_addr`/`im_wdata` until `im_ready`.
- `stop` together with an accept: the instruction is accepted, then DRAIN.
- `start` outside IDLE is ignored.
- Reset mid-load: all state is lost and the block returns to IDLE. Any pending word is discarded.

## Timing
- Reset values: state IDLE, `idx` 0, `in_ready` 0, `im_we` 0, `im_addr` 0, `im_wdata` 0, `busy` 0, `full` 0, `done` 0, `err` 0.
- Latency: accept at edge N → `im_we` high after edge N, i.e. one cycle.
- Throughput: one word per cycle while `im_ready` is held high.
- `full` asserts the cycle after the DEPTH-th accept. `in_ready` is 0 from then on.
- `idx` never wraps. DEPTH == 2^AW is legal because FULL blocks further accepts.

## Configuration
- `ENC_BRANCH_REL_EN` defined:
  - beq treats `target[AW-1:0]` as an absolute word address.
  - The encoded imm is (target − (idx + 1)), computed in 16-bit two's complement and truncated; `imm` is ignored.
- `ENC_BRANCH_REL_EN` undefined: beq encodes `imm` directly and ignores `target`.

## Test plan
- start; add rs=1 rt=2 rd=3 → word 0x00221820 at addr 0 one cycle later. addi rs=0 rt=1 imm=5 → 0x20010005 at addr 1.
- sll rt=1 rd=2 shamt=4 with rs=7 → 0x00011100 (rs forced to 0). j target=0x10 → 0x08000010.
- `ENC_BRANCH_REL_EN`: beq rs=1 rt=2 target=0 as the 3rd word (idx 2) → 0x1022FFFD. Without the macro, imm=0x0003 → 0x10220003.
- Hold `im_ready` low for 3 cycles with a word pending → `im_we`/`im_addr`/`im_wdata` stable and `in_ready` 0. Then 4 back-to-back accepts with `im_ready` high → 4 consecutive addresses.
- mnem=15 between two legal instructions → `err` 1, no write, and the second legal word takes the next address with no gap.
- DEPTH=4: 5 instructions offered → 4 written, `full` 1, `in_ready` 0. Then `stop` → `done` pulse, IDLE. Assert `rstn` low mid-load → all outputs return to reset values.
